// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side drain controller for the dual-clock FIFO (read clock domain).
// Issues pops on rinc/rempty, tracks the fixed RD_LAT read latency, captures returned
// words into a DEPTH-entry skid buffer and presents them on a valid/ready interface.
// Credit (count + pending <= DEPTH) guarantees the skid buffer can never overflow.
//
// Ports:
//   clk        in   read-domain clock (FIFO rclk)
//   rst_n      in   asynchronous active-low reset
//   rempty     in   FIFO empty flag (registered in the FIFO)
//   rinc       out  pop request; only asserted while rempty is low (combinational)
//   rdata      in   FIFO read data, valid RD_LAT cycles after a pop
//   out_valid  out  head word available (decoded from registered pointers)
//   out_data   out  head word
//   out_ready  in   consumer accepts the head word this cycle
//   pending    out  pops issued whose data has not yet arrived
//   deliv_cnt  out  running count of delivered words, wraps at 16 bits
module fifo_rd_drain #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rempty,
    output logic             rinc,
    input  logic [WIDTH-1:0] rdata,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [2:0]       pending,
    output logic [15:0]      deliv_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = PW + 3;

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [PW-1:0]     wp_q, wp_d;
    logic [PW-1:0]     rp_q, rp_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [15:0]       deliv_q, deliv_d;

    logic [PW-1:0]     count;
    logic [2:0]        pend;
    logic              arrive;
    logic              xfer;
    logic              rinc_int;

    // Occupancy and in-flight count; both derive only from registers.
    always_comb begin
        count = wp_q - rp_q;
        pend  = 3'd0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            pend = pend + 3'(vld_q[i]);
        end
    end

    // Pop credit: the word arriving this cycle is still in pend, so the sum never
    // exceeds DEPTH; a same-cycle transfer only frees credit from the next cycle.
    always_comb begin
        rinc_int = ~rempty & ((SW'(count) + SW'(pend)) < SW'(DEPTH));
        arrive   = vld_q[RD_LAT-1];
        xfer     = (count != '0) & out_ready;
    end

    // Next-state: latency shift register, pointers, buffer write, delivery counter.
    always_comb begin
        vld_d    = vld_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        mem_d    = mem_q;
        deliv_d  = deliv_q;

        vld_d[0] = rinc_int;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_d[i] = vld_q[i-1];
        end

        if (arrive) begin
            mem_d[wp_q[AW-1:0]] = rdata;
            wp_d                = wp_q + PW'(1);
        end

        if (xfer) begin
            rp_d    = rp_q + PW'(1);
            deliv_d = deliv_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            deliv_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            deliv_q <= deliv_d;
            mem_q   <= mem_d;
        end
    end

    assign rinc      = rinc_int;
    assign out_valid = (count != '0);
    assign out_data  = mem_q[rp_q[AW-1:0]];
    assign pending   = pend;
    assign deliv_cnt = deliv_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: a queue-based FIFO plus a transaction-level model of the
// drain (skid queue, list of in-flight pops, delivery count). Outputs are compared
// every cycle at the falling edge; inputs change 1 time unit after the rising edge.
module tb_fifo_rd_drain;

    localparam int WIDTH  = 8;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             rempty = 1'b1;
    logic             rinc;
    logic [WIDTH-1:0] rdata = '0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [2:0]       pending;
    logic [15:0]      deliv_cnt;

    always #5 clk = ~clk;

    fifo_rd_drain #(.WIDTH(WIDTH), .RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rempty(rempty), .rinc(rinc), .rdata(rdata),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .pending(pending), .deliv_cnt(deliv_cnt)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // FIFO and drain model state
    logic [WIDTH-1:0] wr_src[$];
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] sk_q[$];
    int               fl_cyc[$];
    logic [WIDTH-1:0] fl_dat[$];
    logic [WIDTH-1:0] rdata_at[int];
    int               m_deliv = 0;
    int unsigned      wr_pct = 100;
    int unsigned      rdy_pct = 0;
    int               full_arr_xfer = 0;

    // Observation logs of actual DUT behaviour
    int               rinc_log[$];
    int               xfer_log[$];
    logic [WIDTH-1:0] deliv_log[$];
    int               val_run, val_best, xfer_run, xfer_best;
    int               rempty_fall, first_valid;
    logic [WIDTH-1:0] first_valid_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        rinc_log.delete();
        xfer_log.delete();
        deliv_log.delete();
        val_run = 0; val_best = 0; xfer_run = 0; xfer_best = 0;
        rempty_fall = -1; first_valid = -1; first_valid_data = '0;
    endtask

    task automatic model_clear();
        wr_src.delete();
        fifo_q.delete();
        sk_q.delete();
        fl_cyc.delete();
        fl_dat.delete();
        rdata_at.delete();
        m_deliv = 0;
    endtask

    task automatic reset_literals(input string tag);
        check({tag, "_rinc"}, 32'(rinc), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_pending"}, 32'(pending), 32'd0);
        check({tag, "_deliv_cnt"}, 32'(deliv_cnt), 32'd0);
    endtask

    // One clock cycle: compare, advance the model, then apply next-cycle inputs.
    task automatic step();
        int   m_cnt, m_pend;
        logic e_rinc, e_valid, xfer, arr;
        logic [WIDTH-1:0] w;
        @(negedge clk);
        m_cnt   = sk_q.size();
        m_pend  = fl_cyc.size();
        e_rinc  = !rempty && (m_cnt + m_pend < DEPTH);
        e_valid = (m_cnt != 0);
        check("rinc", 32'(rinc), 32'(e_rinc));
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("pending", 32'(pending), 32'(m_pend));
        check("deliv_cnt", 32'(deliv_cnt), 32'(16'(m_deliv)));
        if (e_valid) check("out_data", 32'(out_data), 32'(sk_q[0]));
        if (m_cnt + int'(pending) > DEPTH)
            check("credit_bound", 32'(m_cnt + int'(pending)), 32'(DEPTH));

        // Observation logs
        if (rempty === 1'b0 && rempty_fall < 0) rempty_fall = cyc;
        if (rinc === 1'b1) rinc_log.push_back(cyc);
        if (out_valid === 1'b1) begin
            val_run++;
            if (first_valid < 0) begin first_valid = cyc; first_valid_data = out_data; end
        end else val_run = 0;
        if (val_run > val_best) val_best = val_run;
        if (out_valid === 1'b1 && out_ready) begin
            xfer_run++;
            xfer_log.push_back(cyc);
            deliv_log.push_back(out_data);
        end else xfer_run = 0;
        if (xfer_run > xfer_best) xfer_best = xfer_run;

        // Model transitions
        xfer = e_valid && out_ready;
        arr  = (fl_cyc.size() != 0) && (cyc - fl_cyc[0] == RD_LAT);
        if (arr && m_cnt == DEPTH && !xfer) check("overflow_arrival", 32'(m_cnt), 32'(DEPTH - 1));
        // All credit in use, a word lands and one leaves in the same cycle.
        if (arr && xfer && (m_cnt + m_pend == DEPTH)) full_arr_xfer++;
        if (xfer) begin
            void'(sk_q.pop_front());
            m_deliv++;
        end
        if (arr) begin
            sk_q.push_back(fl_dat.pop_front());
            void'(fl_cyc.pop_front());
        end
        if (e_rinc) begin
            w = fifo_q.pop_front();
            fl_cyc.push_back(cyc);
            fl_dat.push_back(w);
            rdata_at[cyc + RD_LAT] = w;
        end

        @(posedge clk);
        #1;
        cyc++;
        if (rst_n && wr_src.size() != 0 && $urandom_range(99) < wr_pct)
            fifo_q.push_back(wr_src.pop_front());
        rempty = (fifo_q.size() == 0) || !rst_n;
        if (rdata_at.exists(cyc)) begin
            rdata = rdata_at[cyc];
            rdata_at.delete(cyc);
        end else begin
            rdata = WIDTH'($urandom);
        end
        out_ready = ($urandom_range(99) < rdy_pct);
    endtask

    // Asynchronous reset pulse landing mid-cycle; the FIFO is reset with it.
    task automatic reset_pulse(input int hold, input string tag);
        #2;
        rst_n  = 1'b0;
        model_clear();
        rempty = 1'b1;
        #1;
        reset_literals(tag);
        repeat (hold) step();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    int errs;
    logic [WIDTH-1:0] src_copy[$];

    initial begin
        clear_logs();
        // Reset and idle
        #1 rst_n = 1'b0;
        #2 reset_literals("por");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) step();
        check("idle_rinc_pulses", 32'(rinc_log.size()), 32'd0);
        check("idle_valid_cycles", 32'(val_best), 32'd0);

        // Single word
        clear_logs();
        rdy_pct = 100; wr_pct = 100;
        wr_src.push_back(8'hA5);
        repeat (10) step();
        check("single_rinc_pulses", 32'(rinc_log.size()), 32'd1);
        if (rinc_log.size() != 0) check("single_rinc_cycle", 32'(rinc_log[0] - rempty_fall), 32'd0);
        check("single_valid_offset", 32'(first_valid - rempty_fall), 32'd3);
        check("single_data", 32'(first_valid_data), 32'hA5);
        check("single_deliv", 32'(deliv_cnt), 32'd1);

        // Streaming 0x00..0x3F
        reset_pulse(2, "rst_stream");
        clear_logs();
        for (int i = 0; i < 64; i++) wr_src.push_back(WIDTH'(i));
        repeat (80) step();
        check("stream_valid_run", 32'(val_best), 32'd64);
        check("stream_xfer_run", 32'(xfer_best), 32'd64);
        check("stream_deliv", 32'(deliv_cnt), 32'd64);
        errs = 0;
        for (int i = 0; i < deliv_log.size(); i++) if (deliv_log[i] !== WIDTH'(i)) errs++;
        check("stream_order_errs", 32'(errs), 32'd0);

        // Back-pressure 0x10..0x1F
        rdy_pct = 0;
        reset_pulse(2, "rst_bp");
        clear_logs();
        for (int i = 0; i < 16; i++) wr_src.push_back(WIDTH'(8'h10 + i));
        repeat (12) step();
        check("bp_pops_during_stall", 32'(rinc_log.size()), 32'd4);
        check("bp_model_count", 32'(sk_q.size()), 32'd4);
        check("bp_pending", 32'(pending), 32'd0);
        check("bp_out_data_head", 32'(out_data), 32'h10);
        clear_logs();
        rdy_pct = 100;
        repeat (40) step();
        if (rinc_log.size() != 0 && xfer_log.size() != 0)
            check("bp_rinc_reassert", 32'(rinc_log[0] - xfer_log[0]), 32'd1);
        else
            check("bp_rinc_reassert_seen", 32'(rinc_log.size() != 0 && xfer_log.size() != 0), 32'd1);
        check("bp_xfer_run", 32'(xfer_best), 32'd16);
        check("bp_deliv", 32'(deliv_cnt), 32'd16);
        errs = 0;
        for (int i = 0; i < deliv_log.size(); i++) if (deliv_log[i] !== WIDTH'(8'h10 + i)) errs++;
        check("bp_order_errs", 32'(errs), 32'd0);

        // Random ready, random FIFO writes, 1000 words
        rdy_pct = 50;
        reset_pulse(2, "rst_rand");
        clear_logs();
        src_copy.delete();
        wr_pct = 60;
        full_arr_xfer = 0;
        for (int i = 0; i < 1000; i++) begin
            wr_src.push_back(WIDTH'($urandom));
            src_copy.push_back(wr_src[i]);
        end
        for (int n = 0; n < 20000 && m_deliv < 1000; n++) step();
        repeat (2) step();
        check("rand_deliv", 32'(deliv_cnt), 32'd1000);
        check("rand_full_arrival_with_xfer", 32'(full_arr_xfer > 0), 32'd1);
        errs = 0;
        for (int i = 0; i < deliv_log.size() && i < src_copy.size(); i++)
            if (deliv_log[i] !== src_copy[i]) errs++;
        check("rand_order_errs", 32'(errs), 32'd0);

        // Reset mid-stream with words buffered and in flight
        rdy_pct = 0; wr_pct = 100;
        reset_pulse(2, "rst_mid_pre");
        clear_logs();
        for (int i = 0; i < 8; i++) wr_src.push_back(WIDTH'(8'h40 + i));
        for (int n = 0; n < 50 && sk_q.size() != 3; n++) step();
        check("mid_reached_count3", 32'(sk_q.size()), 32'd3);
        check("mid_pending_nonzero", 32'(pending != 3'd0), 32'd1);
        reset_pulse(2, "rst_mid");
        clear_logs();
        rdy_pct = 100;
        for (int i = 0; i < 8; i++) wr_src.push_back(WIDTH'(8'h80 + i));
        repeat (30) step();
        check("mid_deliv_words", 32'(deliv_log.size()), 32'd8);
        if (deliv_log.size() != 0) check("mid_first_word", 32'(deliv_log[0]), 32'h80);
        check("mid_deliv_cnt", 32'(deliv_cnt), 32'd8);
        errs = 0;
        for (int i = 0; i < deliv_log.size(); i++) if (deliv_log[i] !== WIDTH'(8'h80 + i)) errs++;
        check("mid_order_errs", 32'(errs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
